// File: rtl/microcode_sequencer.sv
// Instruction timing engine: opcode fetch, length latch, microcode slot walk,
// padding to the exact length, and boundary decisions for halt and interrupt entry.
module microcode_sequencer #(
   parameter int FETCH_CYCLES = 2,
   parameter int SLOT_PITCH   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   output logic       opcode_fetch,
   input  logic [1:0] instr_length,
   output logic       in_irq,
   output logic [2:0] micro_index,
   input  logic [1:0] micro_cycle,
   input  logic       micro_last,
   output logic       reg_fetch_stb,
   output logic       reg_write_stb,
   output logic [3:0] cycle_index,
   output logic       instr_done,
   input  logic       halt_req,
   input  logic       irq_req,
   output logic       irq_ack,
   output logic       halted,
   output logic       seq_error,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_IRQ  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [4:0] FETCH_W    = 5'(FETCH_CYCLES);
   localparam logic [4:0] PITCH_W    = 5'(SLOT_PITCH);
   localparam logic [3:0] LEN_CYCLE5 = 4'd5;
   localparam logic [3:0] LEN_CYCLE7 = 4'd7;
   localparam logic [3:0] LEN_CYCLE12 = 4'd12;

   state_t     state;
   state_t     state_next;
   logic [3:0] cycle_q;
   logic [3:0] len_q;
   logic [2:0] index_q;
   logic       last_seen;
   logic       error_q;

   logic [4:0] cyc;
   logic [4:0] len;
   logic [4:0] pos;
   logic [4:0] phase;
   logic       active;
   logic       fetch_phase;
   logic       issue;
   logic       data;
   logic       final_data;
   logic       last_now;
   logic       last_cycle;
   logic       live;
   logic [3:0] len_decoded;
   logic       len_bad;

   // Every strobe is qualified by ce: one CPU tick per clk with ce=1, nothing moves otherwise.
   always_comb begin
      cyc         = {1'b0, cycle_q};
      len         = {1'b0, len_q};
      active      = (state != ST_HALT);
      fetch_phase = (cyc < FETCH_W);
      pos         = cyc - FETCH_W;
      phase       = pos % PITCH_W;
      // A slot only issues if its data cycle still fits inside the instruction.
      issue       = active && !fetch_phase && (phase == 5'd0) && ((cyc + PITCH_W) <= len);
      data        = active && !fetch_phase && (phase == (PITCH_W - 5'd1)) && ((cyc + 5'd1) <= len);
      final_data  = data && ((cyc + 5'd1 + PITCH_W) > len);
      last_now    = last_seen || (issue && micro_last);
      last_cycle  = active && (cyc == (len - 5'd1));
      live        = ce && !reset;
      len_bad     = (instr_length == 2'd3);
      case (instr_length)
         2'd1:    len_decoded = LEN_CYCLE7;
         2'd2:    len_decoded = LEN_CYCLE12;
         default: len_decoded = LEN_CYCLE5;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_RUN;
         cycle_q   <= 4'd0;
         len_q     <= LEN_CYCLE5;
         index_q   <= 3'd0;
         last_seen <= 1'b0;
         error_q   <= 1'b0;
      end else if (ce) begin
         state <= state_next;
         if (last_cycle || (state == ST_HALT)) begin
            cycle_q   <= 4'd0;
            index_q   <= 3'd0;
            last_seen <= 1'b0;
            if (state_next == ST_IRQ) len_q <= LEN_CYCLE12;
         end else begin
            cycle_q <= cycle_q + 4'd1;
            if ((state == ST_RUN) && (cycle_q == 4'd1)) len_q <= len_decoded;
            if (issue && micro_last) last_seen <= 1'b1;
            if (data && !last_now) index_q <= index_q + 3'd1;
         end
         if ((state == ST_RUN) && (cycle_q == 4'd1) && len_bad) error_q <= 1'b1;
         if (final_data && !last_now) error_q <= 1'b1;
      end
   end

   // Interrupt wins over halt at a boundary; halt is left only through an interrupt.
   always_comb begin
      state_next = state;
      case (state)
         ST_RUN, ST_IRQ: begin
            if (last_cycle) begin
               if (irq_req)       state_next = ST_IRQ;
               else if (halt_req) state_next = ST_HALT;
               else               state_next = ST_RUN;
            end
         end
         ST_HALT: begin
            if (irq_req) state_next = ST_IRQ;
         end
         default: state_next = ST_RUN;
      endcase
   end

   always_comb begin
      opcode_fetch  = live && (state == ST_RUN) && (cycle_q == 4'd0);
      irq_ack       = live && (state == ST_IRQ) && (cycle_q == 4'd0);
      reg_fetch_stb = live && issue && !last_seen && (micro_cycle == 2'd1);
      reg_write_stb = live && issue && !last_seen && (micro_cycle == 2'd2);
      instr_done    = live && last_cycle;
      in_irq        = (state == ST_IRQ);
      halted        = (state == ST_HALT);
      cycle_index   = cycle_q;
      micro_index   = index_q;
      seq_error     = error_q;
      dbg_state     = state;
   end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios then random instructions, checked
// against an instruction-level model of fetch, slot schedule, boundaries and errors.
module tb_microcode_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       ce;
   logic       opcode_fetch;
   logic [1:0] instr_length;
   logic       in_irq;
   logic [2:0] micro_index;
   logic [1:0] micro_cycle;
   logic       micro_last;
   logic       reg_fetch_stb;
   logic       reg_write_stb;
   logic [3:0] cycle_index;
   logic       instr_done;
   logic       halt_req;
   logic       irq_req;
   logic       irq_ack;
   logic       halted;
   logic       seq_error;
   logic [1:0] dbg_state;

   logic [1:0] rom_op [8];
   logic       rom_last [8];

   int n_cmp = 0;
   int n_bad = 0;
   bit err_model = 1'b0;
   int next_mode = 0;   // 0 normal instruction, 1 interrupt sequence, 2 halted

   always #5 clk = ~clk;

   assign micro_cycle = rom_op[micro_index];
   assign micro_last  = rom_last[micro_index];

   microcode_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .ce           (ce),
      .opcode_fetch (opcode_fetch),
      .instr_length (instr_length),
      .in_irq       (in_irq),
      .micro_index  (micro_index),
      .micro_cycle  (micro_cycle),
      .micro_last   (micro_last),
      .reg_fetch_stb(reg_fetch_stb),
      .reg_write_stb(reg_write_stb),
      .cycle_index  (cycle_index),
      .instr_done   (instr_done),
      .halt_req     (halt_req),
      .irq_req      (irq_req),
      .irq_ack      (irq_ack),
      .halted       (halted),
      .seq_error    (seq_error),
      .dbg_state    (dbg_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int min3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b < m) m = b;
      if (c < m) m = c;
      return m;
   endfunction

   task automatic set_rom(input int o0, input int o1, input int o2, input int lp);
      for (int k = 0; k < 8; k++) begin
         rom_op[k]   = 2'd0;
         rom_last[k] = 1'b0;
      end
      rom_op[0] = 2'(o0);
      rom_op[1] = 2'(o1);
      rom_op[2] = 2'(o2);
      if (lp < 8) rom_last[lp] = 1'b1;
   endtask

   task automatic idle(input int n, input int exp_cycle);
      for (int i = 0; i < n; i++) begin
         ce = 1'b0;
         @(negedge clk);
         chk("idle_strobes", {opcode_fetch, irq_ack, reg_fetch_stb, reg_write_stb, instr_done}, 32'd0);
         chk("idle_cycle", cycle_index, exp_cycle);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_instr(input int code, input int gmin, input int gmax, input int stop_at);
      bit irq_seq;
      int n;
      int slots;
      int lastpos;
      int exec;
      irq_seq = (next_mode == 1);
      n = irq_seq ? 12 : ((code == 1) ? 7 : ((code == 2) ? 12 : 5));
      slots = (n - 2) / 2;
      lastpos = 8;
      for (int k = 7; k >= 0; k--) if (rom_last[k]) lastpos = k;
      exec = (lastpos + 1 < slots) ? lastpos + 1 : slots;
      for (int c = 0; c < n && c < stop_at; c++) begin
         int mi;
         int k;
         bit e;
         bit is_issue;
         idle($urandom_range(gmin, gmax), c);
         ce = 1'b1;
         instr_length = (c == 1) ? 2'(code) : 2'($urandom_range(0, 3));
         @(negedge clk);
         mi = (c < 2) ? 0 : min3((c - 2) / 2, slots, lastpos);
         k = (c - 2) / 2;
         is_issue = (c >= 2) && (c % 2 == 0) && (k < exec);
         e = err_model || (!irq_seq && code == 3 && c >= 2) || (lastpos >= slots && c >= 2 * slots + 2);
         chk($sformatf("c%0d cycle_index", c), cycle_index, c);
         chk($sformatf("c%0d opcode_fetch", c), opcode_fetch, !irq_seq && c == 0);
         chk($sformatf("c%0d irq_ack", c), irq_ack, irq_seq && c == 0);
         chk($sformatf("c%0d reg_fetch", c), reg_fetch_stb, is_issue && rom_op[k[2:0]] == 2'd1);
         chk($sformatf("c%0d reg_write", c), reg_write_stb, is_issue && rom_op[k[2:0]] == 2'd2);
         chk($sformatf("c%0d micro_index", c), micro_index, mi);
         chk($sformatf("c%0d instr_done", c), instr_done, c == n - 1);
         chk($sformatf("c%0d in_irq", c), in_irq, irq_seq);
         chk($sformatf("c%0d halted", c), halted, 1'b0);
         chk($sformatf("c%0d seq_error", c), seq_error, e);
         @(posedge clk);
         #1;
      end
      if (stop_at >= n) begin
         err_model = err_model || (!irq_seq && code == 3) || (lastpos >= slots);
         next_mode = irq_req ? 1 : (halt_req ? 2 : 0);
      end
   endtask

   task automatic halt_phase(input int n, input int gmax);
      halt_req = 1'b1;
      irq_req  = 1'b0;
      for (int i = 0; i <= n; i++) begin
         idle($urandom_range(0, gmax), 0);
         ce = 1'b1;
         if (i == n) irq_req = 1'b1;
         @(negedge clk);
         chk("halt_halted", halted, 1'b1);
         chk("halt_strobes", {opcode_fetch, irq_ack, reg_fetch_stb, reg_write_stb, instr_done}, 32'd0);
         chk("halt_cycle", cycle_index, 0);
         chk("halt_micro_index", micro_index, 0);
         chk("halt_in_irq", in_irq, 1'b0);
         @(posedge clk);
         #1;
      end
      irq_req   = 1'b0;
      halt_req  = 1'b0;
      next_mode = 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      ce = 1'b0;
      instr_length = 2'd0;
      halt_req = 1'b0;
      irq_req = 1'b0;
      set_rom(0, 0, 0, 8);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("reset_outputs", {opcode_fetch, irq_ack, reg_fetch_stb, reg_write_stb, instr_done,
                            in_irq, halted, seq_error}, 32'd0);
      chk("reset_cycle", cycle_index, 0);
      chk("reset_micro_index", micro_index, 0);
      @(posedge clk);
      #1;

      // CYCLE5, one write op flagged last; run twice back to back
      set_rom(2, 0, 0, 0);
      run_instr(0, 0, 0, 99);
      run_instr(0, 0, 0, 99);

      // CYCLE12: fetch, fetch, write(last)
      set_rom(1, 1, 2, 2);
      run_instr(2, 0, 0, 99);

      // CYCLE7 with no last flag, then a normal instruction with the sticky error
      set_rom(1, 2, 1, 8);
      run_instr(1, 0, 0, 99);
      set_rom(2, 0, 0, 0);
      run_instr(0, 0, 1, 99);

      // ce 1-of-3, reset at cycle 3 of a CYCLE12
      set_rom(1, 1, 2, 2);
      run_instr(2, 2, 2, 3);
      ce = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_strobes", {opcode_fetch, irq_ack, reg_fetch_stb, reg_write_stb, instr_done}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      ce = 1'b0;
      @(negedge clk);
      chk("rst_mid_outputs", {opcode_fetch, irq_ack, reg_fetch_stb, reg_write_stb, instr_done,
                              in_irq, halted, seq_error}, 32'd0);
      chk("rst_mid_cycle", cycle_index, 0);
      chk("rst_mid_micro_index", micro_index, 0);
      @(posedge clk);
      #1;
      err_model = 1'b0;
      next_mode = 0;
      run_instr(2, 2, 2, 99);

      // halt at a boundary, 20 ticks halted, interrupt wakes into a 12-cycle sequence
      set_rom(2, 0, 0, 0);
      halt_req = 1'b1;
      run_instr(0, 0, 0, 99);
      halt_phase(20, 0);
      set_rom(1, 1, 2, 2);
      run_instr(0, 0, 0, 99);
      run_instr(1, 0, 0, 99);

      // interrupt and halt requested together during a CYCLE7
      irq_req = 1'b1;
      halt_req = 1'b1;
      set_rom(1, 2, 0, 1);
      run_instr(1, 0, 0, 99);
      irq_req = 1'b0;
      halt_req = 1'b0;
      run_instr(0, 0, 0, 99);
      run_instr(0, 0, 0, 99);

      // random instructions, ROM contents, gaps and boundary requests
      for (int t = 0; t < 40; t++) begin
         int lp;
         if (next_mode == 2) halt_phase($urandom_range(1, 6), 1);
         for (int k = 0; k < 8; k++) begin
            rom_op[k]   = 2'($urandom_range(0, 3));
            rom_last[k] = 1'b0;
         end
         lp = $urandom_range(0, 7);
         if (lp < 6) rom_last[lp] = 1'b1;
         irq_req  = ($urandom_range(0, 5) == 0);
         halt_req = ($urandom_range(0, 5) == 0);
         run_instr($urandom_range(0, 3), 0, 2, 99);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
